trace_recorder: RTL and testbench

- Synthesizable capture block for the addac vector flow; the recording counterpart to our vector-playback benches.
- Samples a WIDTH-bit word (e.g. {a, iclk, y}) from a DUT into an internal buffer after an arm/trigger sequence.
- Streams the stored words back out over a valid/ready port, in capture order, so they can be dumped in the same layout as our .tv files.

---
 rtl/trace_recorder.sv | 142 ++++++++++++++
 tb/tb_trace_recorder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_recorder.sv
// rtl/trace_recorder.sv - arm/trigger capture buffer with in-order valid/ready readout
module trace_recorder #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 18,
  localparam int AW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             arm,
  input  logic             trig,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_start,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    count,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE,
    S_READOUT
  } state_t;

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  state_t            state, next_state;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              we;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    we         = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) next_state = S_ARMED;
      end
      S_ARMED: begin
        busy = 1'b1;
        if (trig) begin
          next_state = S_CAPTURE;
          we         = sample_en;
        end
      end
      S_CAPTURE: begin
        busy = 1'b1;
        we   = sample_en && (wr_ptr < DEPTH_W);
        if (stop || (we && count == DEPTH_W - 1'b1)) next_state = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (rd_start) next_state = (count == '0) ? S_IDLE : S_READOUT;
      end
      S_READOUT: begin
        if (rd_valid && rd_ready && rd_ptr == count - 1'b1) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (clear) begin
      next_state = S_IDLE;
      we         = 1'b0;
    end
  end

  // Buffer has no reset; its contents only matter up to count.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            count    <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (sample_en && count == DEPTH_W) overflow <= 1'b1;
          if (rd_start) begin
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
          end
        end
        S_READOUT: begin
          // First cycle primes the output register; later handshakes prefetch the next word.
          if (!rd_valid) begin
            rd_data  <= mem[rd_ptr];
            rd_valid <= 1'b1;
          end else if (rd_ready) begin
            if (rd_ptr == count - 1'b1) begin
              rd_valid <= 1'b0;
            end else begin
              rd_ptr  <= rd_ptr + 1'b1;
              rd_data <= mem[rd_ptr + 1'b1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_recorder.sv
// tb/tb_trace_recorder.sv - randomized directed bench for trace_recorder against a queue model
module tb_trace_recorder;

  localparam int WIDTH = 3;
  localparam int DEPTH = 18;
  localparam int AW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             arm = 1'b0;
  logic             trig = 1'b0;
  logic             stop = 1'b0;
  logic             sample_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_start = 1'b0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    count;
  logic             done;
  logic             busy;
  logic             overflow;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] model_q[$];

  trace_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .arm(arm), .trig(trig), .stop(stop),
    .sample_en(sample_en), .din(din), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .done(done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in ARMED; stores n words. Data cycles 0..7 or is random; sample gaps optional.
  task automatic capture(input int n, input bit gaps, input bit stop_last, input bit cyc);
    int guard;
    bit stopped;
    guard = 0;
    stopped = 0;
    model_q.delete();
    trig = 1'b1;
    while (model_q.size() < n && guard < 300) begin
      sample_en = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      din = cyc ? WIDTH'(model_q.size() % 8) : WIDTH'($urandom_range(0, 7));
      arm = (guard == 1);
      stop = stop_last && sample_en && (model_q.size() == n - 1);
      if (stop) stopped = 1;
      if (sample_en) model_q.push_back(din);
      tick();
      guard++;
      trig = 1'b0; stop = 1'b0; sample_en = 1'b0; arm = 1'b0;
      chk("cap_count", count, model_q.size());
      chk("cap_busy", busy, (model_q.size() < DEPTH) && !stopped);
    end
    chk("cap_words", model_q.size(), n);
  endtask

  task automatic readout(input int stall, input bit rnd);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b0;
    chk("rd_lat0_valid", rd_valid, 0);
    chk("rd_lat0_done", done, 0);
    tick();
    chk("rd_lat1_valid", rd_valid, 1);
    while (got < model_q.size() && cyc < 400) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, model_q[got]);
      rd_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      tick();
      cyc++;
      if (rd_ready) got++;
    end
    rd_ready = 1'b0;
    chk("rd_all", got, model_q.size());
    chk("rd_end_valid", rd_valid, 0);
    chk("rd_end_done", done, 0);
    chk("rd_end_busy", busy, 0);
    chk("rd_end_count", count, model_q.size());
  endtask

  initial begin
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);

    // Controls other than arm do nothing in IDLE
    trig = 1'b1; sample_en = 1'b1; stop = 1'b1; rd_start = 1'b1; din = 3'd5;
    tick();
    trig = 1'b0; sample_en = 1'b0; stop = 1'b0; rd_start = 1'b0;
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_count", count, 0);
    chk("idle_ign_done", done, 0);

    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_busy", busy, 1);
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("armed_rdstart_busy", busy, 1);
    chk("armed_rdstart_valid", rd_valid, 0);

    // Full capture, trigger cycle included
    capture(DEPTH, 1'b0, 1'b0, 1'b1);
    chk("full_done", done, 1);
    chk("full_count", count, DEPTH);
    chk("full_ovf", overflow, 0);
    readout(3, 1'b0);

    // Early stop after 5 words
    arm = 1'b1; tick(); arm = 1'b0;
    capture(5, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_done", done, 1);
    chk("stop_count", count, 5);
    sample_en = 1'b1; tick(); sample_en = 1'b0;
    chk("stop_sample_ovf", overflow, 0);
    chk("stop_sample_count", count, 5);
    readout(0, 1'b1);

    // Fill with stop on the final write, then overflow in DONE
    arm = 1'b1; tick(); arm = 1'b0;
    capture(DEPTH, 1'b1, 1'b1, 1'b0);
    chk("fill_stop_done", done, 1);
    chk("fill_stop_count", count, DEPTH);
    chk("fill_stop_ovf", overflow, 0);
    sample_en = 1'b1; din = 3'd7; tick(); sample_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_done", done, 1);
    readout(0, 1'b1);
    chk("ovf_sticky", overflow, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("ovf_arm_clr", overflow, 0);
    chk("ovf_arm_busy", busy, 1);

    // Async reset mid-capture
    capture(7, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", count, 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_busy", busy, 0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // Clear during readout
    arm = 1'b1; tick(); arm = 1'b0;
    capture(3, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    tick();
    chk("clr_pre_valid", rd_valid, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_valid", rd_valid, 0);
    chk("clr_count", count, 0);
    chk("clr_data", rd_data, 0);
    chk("clr_done", done, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("clr_then_arm", busy, 1);

    // Zero-sample capture: rd_start returns straight to IDLE
    trig = 1'b1; tick(); trig = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_count", count, 0);
    rd_start = 1'b1; rd_ready = 1'b1; tick(); rd_start = 1'b0;
    chk("zero_rd_done", done, 0);
    chk("zero_rd_valid0", rd_valid, 0);
    tick();
    chk("zero_rd_valid1", rd_valid, 0);
    tick();
    chk("zero_rd_valid2", rd_valid, 0);
    rd_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("zero_idle_arm", busy, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
